// File: rtl/cbf_frontend_sched.sv
// Input framing and strobe scheduling for a two-stage control-bounded filter front end.
// Builds the lookahead window and lookback groups and tracks history fill across decimation changes.
module cbf_frontend_sched #(
  parameter int unsigned M        = 4,
  parameter int unsigned DSR1     = 2,
  parameter int unsigned DSR2_MAX = 8,
  parameter int unsigned DSR2_DEF = 6,
  parameter int unsigned DEPTH    = 72,
  parameter int unsigned LB_DELAY = 2,
  parameter int unsigned OUT_LAT  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [M-1:0]                      in,
  input  logic                              cfg_load,
  input  logic [$clog2(DSR2_MAX+1)-1:0]     cfg_dsr2,
  output logic [M*DEPTH-1:0]                ahead,
  output logic [M*DSR1-1:0]                 back,
  output logic                              en_rec,
  output logic                              en_ds,
  output logic                              compute_valid,
  output logic                              out_valid,
  output logic                              cfg_err,
  output logic [$clog2(DSR2_MAX+1)-1:0]     dsr2_act
);

  localparam int unsigned H   = DEPTH + (LB_DELAY + 1) * DSR1;
  localparam int unsigned B   = DEPTH + LB_DELAY * DSR1;
  localparam int unsigned DW  = $clog2(DSR2_MAX + 1);
  localparam int unsigned C1W = (DSR1 > 1) ? $clog2(DSR1) : 1;
  localparam int unsigned AW  = $clog2(H + DSR1 * DSR2_MAX + 1);
  localparam int unsigned WW  = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;

  typedef enum logic [1:0] {StFill, StWait, StRun} state_e;

  logic [M-1:0]       hist_q [H];
  logic [M-1:0]       hist_d [H];
  logic [M*DEPTH-1:0] ahead_q, ahead_d;
  logic [M*DSR1-1:0]  back_q, back_d;
  logic               en_rec_q, en_rec_d, en_ds_q, en_ds_d;
  logic               cv_q, cv_d, ov_q, ov_d, err_q, err_d;
  logic [DW-1:0]      dsr2_q, dsr2_d;
  logic [C1W-1:0]     c1_q, c1_d;
  logic [DW-1:0]      c2_q, c2_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  state_e             state_q, state_d;

  logic          rec, ds, cfg_ok;
  logic [AW-1:0] k_val;

  always_comb begin
    k_val  = AW'(DSR1 * dsr2_q);
    rec    = (c1_q == C1W'(DSR1 - 1));
    ds     = rec && (c2_q == dsr2_q - DW'(1));
    cfg_ok = (cfg_dsr2 != '0) && (cfg_dsr2 <= DW'(DSR2_MAX));

    hist_d[0] = in;
    for (int j = 1; j < H; j++) hist_d[j] = hist_q[j-1];

    ahead_d  = ahead_q;
    back_d   = back_q;
    en_rec_d = 1'b0;
    en_ds_d  = 1'b0;
    cv_d     = cv_q;
    ov_d     = ov_q;
    err_d    = err_q;
    dsr2_d   = dsr2_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    state_d  = state_q;

    if (cfg_load && cfg_ok) begin
      // Accepted load restarts scheduling and fill tracking but keeps the sample history.
      dsr2_d  = cfg_dsr2;
      c1_d    = '0;
      c2_d    = '0;
      acc_d   = '0;
      wcnt_d  = '0;
      cv_d    = 1'b0;
      ov_d    = 1'b0;
      state_d = StFill;
    end else begin
      if (cfg_load) err_d = 1'b1;
      c1_d = rec ? '0 : c1_q + C1W'(1);
      if (rec) c2_d = ds ? '0 : c2_q + DW'(1);
      en_rec_d = rec;
      en_ds_d  = ds;
      if (rec) begin
        for (int j = 0; j < DSR1; j++) back_d[M*j +: M] = hist_q[B+j];
      end
      if (ds) begin
        for (int i = 0; i < DEPTH; i++) ahead_d[M*i +: M] = hist_q[DEPTH-1-i];
        unique case (state_q)
          StFill: begin
            // Fill completes on the first event whose cumulative sample count covers H.
            if (acc_q + k_val >= AW'(H)) begin
              cv_d  = 1'b1;
              acc_d = '0;
              if (OUT_LAT == 0) begin
                ov_d    = 1'b1;
                state_d = StRun;
              end else begin
                state_d = StWait;
              end
            end else begin
              acc_d = acc_q + k_val;
            end
          end
          StWait: begin
            if (wcnt_q == WW'(OUT_LAT - 1)) begin
              ov_d    = 1'b1;
              state_d = StRun;
            end else begin
              wcnt_d = wcnt_q + WW'(1);
            end
          end
          StRun:   ;
          default: state_d = StFill;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q   <= '{default: '0};
      ahead_q  <= '0;
      back_q   <= '0;
      en_rec_q <= 1'b0;
      en_ds_q  <= 1'b0;
      cv_q     <= 1'b0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
      dsr2_q   <= DW'(DSR2_DEF);
      c1_q     <= '0;
      c2_q     <= '0;
      acc_q    <= '0;
      wcnt_q   <= '0;
      state_q  <= StFill;
    end else begin
      hist_q   <= hist_d;
      ahead_q  <= ahead_d;
      back_q   <= back_d;
      en_rec_q <= en_rec_d;
      en_ds_q  <= en_ds_d;
      cv_q     <= cv_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
      dsr2_q   <= dsr2_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      acc_q    <= acc_d;
      wcnt_q   <= wcnt_d;
      state_q  <= state_d;
    end
  end

  assign ahead         = ahead_q;
  assign back          = back_q;
  assign en_rec        = en_rec_q;
  assign en_ds         = en_ds_q;
  assign compute_valid = cv_q;
  assign out_valid     = ov_q;
  assign cfg_err       = err_q;
  assign dsr2_act      = dsr2_q;

endmodule

// File: tb/tb_cbf_frontend_sched.sv
// Scoreboard bench for cbf_frontend_sched: stimulus pushes expected per-edge records,
// a negedge monitor pops them and compares every output each cycle.
module tb_cbf_frontend_sched;

  localparam int unsigned M        = 1;
  localparam int unsigned DSR1     = 2;
  localparam int unsigned DSR2_MAX = 8;
  localparam int unsigned DSR2_DEF = 6;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned LB_DELAY = 2;
  localparam int unsigned OUT_LAT  = 2;
  localparam int          HH       = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] in_s = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_dsr2 = 4'd0;
  logic [7:0] ahead;
  logic [1:0] back;
  logic       en_rec, en_ds, compute_valid, out_valid, cfg_err;
  logic [3:0] dsr2_act;

  always #5 clk = ~clk;

  cbf_frontend_sched #(
    .M(M), .DSR1(DSR1), .DSR2_MAX(DSR2_MAX), .DSR2_DEF(DSR2_DEF),
    .DEPTH(DEPTH), .LB_DELAY(LB_DELAY), .OUT_LAT(OUT_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in(in_s), .cfg_load(cfg_load), .cfg_dsr2(cfg_dsr2),
    .ahead(ahead), .back(back), .en_rec(en_rec), .en_ds(en_ds),
    .compute_valid(compute_valid), .out_valid(out_valid), .cfg_err(cfg_err),
    .dsr2_act(dsr2_act)
  );

  typedef struct {
    int         edge_n;
    logic       rec;
    logic       ds;
    logic [7:0] ahead;
    logic [1:0] back;
    logic       cv;
    logic       ov;
    logic       err;
    logic [3:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Bench-side schedule state, derived from the timing rules.
  logic       samp [0:1023];
  int         floor_e = 0;
  int         last_l = 0;
  int         kk = 12;
  int         ds_cnt = 0;
  int         fill_ds = 2;
  logic [7:0] ex_ahead = '0;
  logic [1:0] ex_back = '0;
  logic       ex_err = 1'b0;
  logic [3:0] ex_d = 4'd6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic get_s(input int idx);
    return (idx <= floor_e) ? 1'b0 : samp[idx];
  endfunction

  task automatic push_rec(input int e, input logic rec, input logic ds);
    exp_t r;
    r.edge_n = e;
    r.rec    = rec;
    r.ds     = ds;
    r.ahead  = ex_ahead;
    r.back   = ex_back;
    r.cv     = (ds_cnt >= fill_ds);
    r.ov     = (ds_cnt >= fill_ds + int'(OUT_LAT));
    r.err    = ex_err;
    r.d      = ex_d;
    q.push_back(r);
  endtask

  task automatic step(input logic v, input logic ld, input logic [3:0] d, input logic r);
    logic rec, ds;
    in_s = v;
    cfg_load = ld;
    cfg_dsr2 = d;
    rst = r;
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      last_l = cyc; kk = 12; ds_cnt = 0; fill_ds = 2;
      ex_ahead = '0; ex_back = '0; ex_err = 1'b0; ex_d = 4'd6; floor_e = cyc;
      push_rec(cyc, 1'b0, 1'b0);
    end else if (ld && d >= 4'd1 && d <= 4'd8) begin
      samp[cyc] = v;
      last_l = cyc; ex_d = d; kk = 2 * int'(d); ds_cnt = 0;
      fill_ds = (HH + kk - 1) / kk;
      push_rec(cyc, 1'b0, 1'b0);
    end else begin
      samp[cyc] = v;
      if (ld) ex_err = 1'b1;
      rec = ((cyc - last_l) % 2 == 0);
      ds  = rec && ((cyc - last_l) % kk == 0);
      if (rec) for (int j = 0; j < 2; j++) ex_back[j] = get_s(cyc - 13 - j);
      if (ds) begin
        for (int i = 0; i < 8; i++) ex_ahead[i] = get_s(cyc - 8 + i);
        ds_cnt++;
      end
      if (rec || ld) push_rec(cyc, rec, ds);
    end
  endtask

  // Monitor: outputs registered at edge cyc are sampled at the following negedge.
  initial begin
    exp_t h;
    h.edge_n = 0; h.rec = 0; h.ds = 0; h.ahead = '0; h.back = '0;
    h.cv = 0; h.ov = 0; h.err = 0; h.d = 4'd6;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        while (q.size() > 0 && q[0].edge_n < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_record cyc=%0d got=none exp=edge %0d", cyc, q[0].edge_n);
          void'(q.pop_front());
        end
        h.rec = 1'b0;
        h.ds  = 1'b0;
        if (q.size() > 0 && q[0].edge_n == cyc) h = q.pop_front();
        chk("en_rec", 32'(en_rec), 32'(h.rec));
        chk("en_ds", 32'(en_ds), 32'(h.ds));
        chk("ahead", 32'(ahead), 32'(h.ahead));
        chk("back", 32'(back), 32'(h.back));
        chk("compute_valid", 32'(compute_valid), 32'(h.cv));
        chk("out_valid", 32'(out_valid), 32'(h.ov));
        chk("cfg_err", 32'(cfg_err), 32'(h.err));
        chk("dsr2_act", 32'(dsr2_act), 32'(h.d));
      end
    end
  end

  initial begin
    int base;
    logic v, ld, r;
    logic [3:0] d;
    for (int i = 0; i < 1024; i++) samp[i] = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
    base = cyc;
    // Single 1 on the first active edge, then zeros through out_valid.
    for (int e = 1; e <= 48; e++) step(e == 1, 1'b0, 4'd0, 1'b1);
    for (int e = 49; e <= 215; e++) begin
      v  = 1'((e >> 1) ^ (e >> 3));
      ld = 1'b0;
      d  = 4'd0;
      r  = 1'b1;
      case (e)
        113: begin ld = 1'b1; d = 4'd0; end
        120: begin ld = 1'b1; d = 4'd9; end
        126: begin ld = 1'b1; d = 4'd3; end
        170: begin ld = 1'b1; d = 4'd3; r = 1'b0; end
        180: begin ld = 1'b1; d = 4'd4; end
        default: ;
      endcase
      step(v, ld, d, r);
    end
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("cycle_count", 32'(cyc - base), 32'd217);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
